// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM burst responder and its bus interface.
package sram_pkg;
  localparam int SRAM_ADDR_W       = 24;
  localparam int SRAM_DATA_W       = 16;
  localparam int SRAM_READ_CYCLES  = 2;
  localparam int SRAM_WRITE_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    ACK,
    RECOVER
  } sram_resp_state_t;
endpackage

// File: rtl/sram_burst_responder_if.sv
// Requester-side request/burst bus between the arbiter (master) and the SRAM responder (slave).
interface sram_burst_responder_if;
  import sram_pkg::*;

  logic                   sram_req;
  logic                   sram_we;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [31:0]            sram_wdata;
  logic [7:0]             sram_burst_len;
  logic [31:0]            sram_rdata;
  logic                   sram_ack;
  logic                   sram_ready;
  logic [SRAM_DATA_W-1:0] sram_burst_rdata;
  logic                   sram_burst_data_valid;

  modport master (
    output sram_req, sram_we, sram_addr, sram_wdata, sram_burst_len,
    input  sram_rdata, sram_ack, sram_ready, sram_burst_rdata, sram_burst_data_valid
  );

  modport slave (
    input  sram_req, sram_we, sram_addr, sram_wdata, sram_burst_len,
    output sram_rdata, sram_ack, sram_ready, sram_burst_rdata, sram_burst_data_valid
  );
endinterface

// File: rtl/sram_burst_responder.sv
// Drives a 16-bit async SRAM: 32-bit single reads/writes and N-word burst reads.
// Optional feature: define SRAM_BURST_CANCEL_EN to let a dropped request end a burst early.
module sram_burst_responder
  import sram_pkg::*;
#(
  parameter int READ_CYCLES  = SRAM_READ_CYCLES,
  parameter int WRITE_CYCLES = SRAM_WRITE_CYCLES
) (
  input  logic                   clk_sram,
  input  logic                   rst_n_sram,
  sram_burst_responder_if.slave  bus,
  output logic [SRAM_ADDR_W-1:0] sram_a,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);

  sram_resp_state_t       state;
  logic [SRAM_DATA_W-1:0] wdata_hi;
  logic [7:0]             len_q;
  logic [7:0]             beat;
  logic [CNT_W-1:0]       cnt;
  logic                   rd_done;
  logic [SRAM_DATA_W-1:0] rd_lo;
  logic [SRAM_DATA_W-1:0] rd_hi;

  logic [CNT_W-1:0] cnt_nx;
  logic [7:0]       last_beat;
  logic             is_burst;
  logic             stop_rd;

  assign bus.sram_ready = (state == IDLE);
  assign cnt_nx         = cnt + CNT_W'(1);
  assign is_burst       = (len_q != 8'd0);
  assign last_beat      = is_burst ? (len_q - 8'd1) : 8'd1;

`ifdef SRAM_BURST_CANCEL_EN
  logic cancel_q;
  // A low request seen at any point of a burst ends it once the current access is sampled.
  assign stop_rd = (beat == last_beat) || (is_burst && (cancel_q || !bus.sram_req));
`else
  assign stop_rd = (beat == last_beat);
`endif

  // Reads insert one settle cycle (rd_done) after the last sample so the final beat
  // is presented before ack; writes go straight to ACK after their second access.
  always_ff @(posedge clk_sram or negedge rst_n_sram) begin
    if (!rst_n_sram) begin
      state                     <= IDLE;
      wdata_hi                  <= '0;
      len_q                     <= '0;
      beat                      <= '0;
      cnt                       <= '0;
      rd_done                   <= 1'b0;
      rd_lo                     <= '0;
      rd_hi                     <= '0;
      bus.sram_ack              <= 1'b0;
      bus.sram_rdata            <= '0;
      bus.sram_burst_rdata      <= '0;
      bus.sram_burst_data_valid <= 1'b0;
      sram_a                    <= '0;
      sram_dq_o                 <= '0;
      sram_dq_oe                <= 1'b0;
      sram_ce_n                 <= 1'b1;
      sram_oe_n                 <= 1'b1;
      sram_we_n                 <= 1'b1;
`ifdef SRAM_BURST_CANCEL_EN
      cancel_q                  <= 1'b0;
`endif
    end else begin
      bus.sram_burst_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sram_req) begin
            wdata_hi  <= bus.sram_wdata[31:16];
            len_q     <= bus.sram_burst_len;
            beat      <= '0;
            cnt       <= '0;
            rd_done   <= 1'b0;
            sram_a    <= bus.sram_addr;
            sram_ce_n <= 1'b0;
`ifdef SRAM_BURST_CANCEL_EN
            cancel_q  <= 1'b0;
`endif
            if (bus.sram_we) begin
              state      <= WR;
              sram_we_n  <= 1'b0;
              sram_dq_oe <= 1'b1;
              sram_dq_o  <= bus.sram_wdata[15:0];
            end else begin
              state     <= RD;
              sram_oe_n <= 1'b0;
            end
          end
        end
        RD: begin
`ifdef SRAM_BURST_CANCEL_EN
          if (is_burst && !bus.sram_req) cancel_q <= 1'b1;
`endif
          if (rd_done) begin
            state        <= ACK;
            bus.sram_ack <= 1'b1;
            if (!is_burst) bus.sram_rdata <= {rd_hi, rd_lo};
          end else if (cnt == RD_LAST) begin
            cnt <= '0;
            if (is_burst) begin
              bus.sram_burst_rdata      <= sram_dq_i;
              bus.sram_burst_data_valid <= 1'b1;
            end else if (beat == 8'd0) begin
              rd_lo <= sram_dq_i;
            end else begin
              rd_hi <= sram_dq_i;
            end
            if (stop_rd) begin
              rd_done   <= 1'b1;
              sram_ce_n <= 1'b1;
              sram_oe_n <= 1'b1;
            end else begin
              beat   <= beat + 8'd1;
              sram_a <= sram_a + SRAM_ADDR_W'(1);
            end
          end else begin
            cnt <= cnt_nx;
          end
        end
        WR: begin
          if (cnt == WR_LAST) begin
            cnt <= '0;
            if (beat == 8'd0) begin
              beat      <= 8'd1;
              sram_a    <= sram_a + SRAM_ADDR_W'(1);
              sram_dq_o <= wdata_hi;
              sram_we_n <= 1'b0;
            end else begin
              state        <= ACK;
              bus.sram_ack <= 1'b1;
              sram_ce_n    <= 1'b1;
              sram_we_n    <= 1'b1;
              sram_dq_oe   <= 1'b0;
            end
          end else begin
            cnt       <= cnt_nx;
            sram_we_n <= (cnt_nx == WR_LAST);
          end
        end
        ACK: begin
          bus.sram_ack <= 1'b0;
          state        <= RECOVER;
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_responder.sv
// Randomised self-checking bench for sram_burst_responder against an async SRAM model and a reference memory.
module tb_sram_burst_responder;
  localparam int R = 2;
  localparam int W = 2;

  logic        clk;
  logic        rst_n;
  logic [23:0] sram_a;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  sram_burst_responder_if bus();

  sram_burst_responder #(.READ_CYCLES(R), .WRITE_CYCLES(W)) dut (
    .clk_sram   (clk),
    .rst_n_sram (rst_n),
    .bus        (bus.slave),
    .sram_a     (sram_a),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pin-level SRAM contents and the bench's own expectation of memory contents.
  logic [15:0] sram_mem [logic [23:0]];
  logic [15:0] ref_mem  [logic [23:0]];

  function automatic logic [15:0] init_word(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], 8'hA5};
  endfunction

  function automatic logic [15:0] sram_rd(input logic [23:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Async SRAM: read data settles within half a cycle, writes commit on the rising edge of we_n.
  always @(negedge clk)
    sram_dq_i = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) ? sram_rd(sram_a) : 16'hDEAD;

  always @(posedge sram_we_n)
    if (sram_ce_n === 1'b0 && sram_dq_oe === 1'b1) sram_mem[sram_a] = sram_dq_o;

  function automatic logic [94:0] snapshot();
    return {bus.sram_ready, bus.sram_ack, bus.sram_burst_data_valid, bus.sram_rdata,
            bus.sram_burst_rdata, sram_a, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n};
  endfunction

  localparam logic [94:0] RESET_SNAP = {1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 24'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1};

  // Observations of the most recent transaction (cycle 0 = acceptance cycle).
  int          ack_cyc, rdy_cyc, ack_cnt, wen_low, oe_cyc;
  logic [31:0] rdata_at_ack;
  logic [15:0] beat_data[$];
  int          beat_cyc[$];
  logic [23:0] a_seq[$];
  bit          timed_out;

  task automatic run_txn(input bit we, input logic [23:0] addr, input logic [31:0] wdata,
                         input logic [7:0] len, input int drop_at, input bit keep_req);
    int c;
    int guard;
    beat_data.delete(); beat_cyc.delete(); a_seq.delete();
    ack_cyc = 0; rdy_cyc = 0; ack_cnt = 0; wen_low = 0; oe_cyc = 0; timed_out = 0;
    @(negedge clk);
    guard = 0;
    while (bus.sram_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    bus.sram_req = 1'b1; bus.sram_we = we; bus.sram_addr = addr;
    bus.sram_wdata = wdata; bus.sram_burst_len = len;
    @(posedge clk);
    c = 0;
    while (rdy_cyc == 0 && c < 2000) begin
      @(negedge clk);
      c++;
      if (c == drop_at) bus.sram_req = 1'b0;
      if (bus.sram_burst_data_valid === 1'b1) begin
        beat_data.push_back(bus.sram_burst_rdata);
        beat_cyc.push_back(c);
      end
      if (sram_ce_n === 1'b0 && sram_oe_n === 1'b0 && (a_seq.size() == 0 || a_seq[$] !== sram_a))
        a_seq.push_back(sram_a);
      if (sram_we_n === 1'b0) wen_low++;
      if (sram_dq_oe === 1'b1) oe_cyc++;
      if (ack_cyc != 0 && bus.sram_ready === 1'b1) rdy_cyc = c;
      if (bus.sram_ack === 1'b1) begin
        ack_cnt++;
        if (ack_cyc == 0) ack_cyc = c;
        rdata_at_ack = bus.sram_rdata;
        if (!keep_req) bus.sram_req = 1'b0;
      end
    end
    if (rdy_cyc == 0) begin
      timed_out = 1;
      bus.sram_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sram_req = 1'b0; bus.sram_we = 1'b0; bus.sram_addr = '0;
    bus.sram_wdata = '0; bus.sram_burst_len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (snapshot() !== RESET_SNAP)
      begin errors++; $display("[TB] FAIL reset_hold: got %h, expected %h", snapshot(), RESET_SNAP); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (snapshot() !== RESET_SNAP)
      begin errors++; $display("[TB] FAIL reset_release: got %h, expected %h", snapshot(), RESET_SNAP); end
  endtask

  task automatic test_single_read();
    sram_mem[24'h100] = 16'hBEEF; ref_mem[24'h100] = 16'hBEEF;
    sram_mem[24'h101] = 16'h1234; ref_mem[24'h101] = 16'h1234;
    run_txn(1'b0, 24'h000100, 32'h0, 8'd0, 0, 1'b0);
    checks++;
    if (rdata_at_ack !== 32'h1234BEEF)
      begin errors++; $display("[TB] FAIL single_read_data: got %h, expected %h", rdata_at_ack, 32'h1234BEEF); end
    checks++;
    if (ack_cyc !== 2 + 2 * R)
      begin errors++; $display("[TB] FAIL single_read_ack: got cycle %0d, expected %0d", ack_cyc, 2 + 2 * R); end
    checks++;
    if (rdy_cyc !== ack_cyc + 2)
      begin errors++; $display("[TB] FAIL single_read_ready: got cycle %0d, expected %0d", rdy_cyc, ack_cyc + 2); end
  endtask

  task automatic test_single_write();
    run_txn(1'b1, 24'h000200, 32'hCAFE5A5A, 8'd7, 0, 1'b0);
    ref_mem[24'h200] = 16'h5A5A; ref_mem[24'h201] = 16'hCAFE;
    checks++;
    if (ack_cyc !== 1 + 2 * W)
      begin errors++; $display("[TB] FAIL single_write_ack: got cycle %0d, expected %0d", ack_cyc, 1 + 2 * W); end
    checks++;
    if ({sram_rd(24'h201), sram_rd(24'h200)} !== 32'hCAFE5A5A)
      begin errors++; $display("[TB] FAIL single_write_mem: got %h, expected %h", {sram_rd(24'h201), sram_rd(24'h200)}, 32'hCAFE5A5A); end
    checks++;
    if (wen_low !== 2 * (W - 1))
      begin errors++; $display("[TB] FAIL single_write_we_n: got %0d low cycles, expected %0d", wen_low, 2 * (W - 1)); end
    checks++;
    if (oe_cyc !== 2 * W)
      begin errors++; $display("[TB] FAIL single_write_dq_oe: got %0d cycles, expected %0d", oe_cyc, 2 * W); end
  endtask

  task automatic test_burst_128();
    run_txn(1'b0, 24'h001000, 32'h0, 8'd128, 0, 1'b0);
    checks++;
    if (beat_data.size() !== 128)
      begin errors++; $display("[TB] FAIL burst128_beats: got %0d, expected %0d", beat_data.size(), 128); end
    for (int k = 0; k < beat_data.size() && k < 128; k++) begin
      checks++;
      if (beat_data[k] !== ref_rd(24'h001000 + 24'(k)) || beat_cyc[k] !== 1 + (k + 1) * R)
        begin errors++; $display("[TB] FAIL burst128_beat%0d: got %h@%0d, expected %h@%0d", k, beat_data[k], beat_cyc[k], ref_rd(24'h001000 + 24'(k)), 1 + (k + 1) * R); end
    end
    checks++;
    if (ack_cyc !== 2 + 128 * R || rdy_cyc !== 4 + 128 * R)
      begin errors++; $display("[TB] FAIL burst128_ack_ready: got %0d/%0d, expected %0d/%0d", ack_cyc, rdy_cyc, 2 + 128 * R, 4 + 128 * R); end
    checks++;
    if (bus.sram_rdata !== 32'h1234BEEF)
      begin errors++; $display("[TB] FAIL rdata_hold: got %h, expected %h", bus.sram_rdata, 32'h1234BEEF); end
  endtask

  task automatic test_burst_wrap();
    run_txn(1'b0, 24'hFFFFFE, 32'h0, 8'd3, 0, 1'b0);
    checks++;
    if (a_seq.size() !== 3 || a_seq[0] !== 24'hFFFFFE || a_seq[1] !== 24'hFFFFFF || a_seq[2] !== 24'h000000)
      begin errors++; $display("[TB] FAIL wrap_addr: got %0d addrs first %h last %h, expected FFFFFE..000000", a_seq.size(), a_seq.size() ? a_seq[0] : 24'h0, a_seq.size() ? a_seq[$] : 24'h0); end
    checks++;
    if (beat_data.size() !== 3 || beat_data[2] !== ref_rd(24'h000000))
      begin errors++; $display("[TB] FAIL wrap_data: got %0d beats, expected 3 ending %h", beat_data.size(), ref_rd(24'h000000)); end
  endtask

  task automatic test_reset_abort();
    bit saw_ack;
    @(negedge clk);
    bus.sram_req = 1'b1; bus.sram_we = 1'b0; bus.sram_addr = 24'h004000; bus.sram_burst_len = 8'd50;
    @(posedge clk);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    bus.sram_req = 1'b0;
    checks++;
    if (snapshot() !== RESET_SNAP)
      begin errors++; $display("[TB] FAIL reset_abort: got %h, expected %h", snapshot(), RESET_SNAP); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_ack = 0;
    repeat (10) begin @(negedge clk); if (bus.sram_ack === 1'b1) saw_ack = 1; end
    checks++;
    if (saw_ack || bus.sram_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL reset_abort_idle: got ack=%0d ready=%b, expected ack=0 ready=1", saw_ack, bus.sram_ready); end
  endtask

  task automatic test_back_to_back();
    int c;
    run_txn(1'b0, 24'h000100, 32'h0, 8'd0, 0, 1'b1);
    checks++;
    if (rdy_cyc !== ack_cyc + 2 || sram_ce_n !== 1'b1)
      begin errors++; $display("[TB] FAIL b2b_recover: got ready@%0d ce_n=%b, expected ready@%0d ce_n=1", rdy_cyc, sram_ce_n, ack_cyc + 2); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, bus.sram_ready} !== 3'b000)
      begin errors++; $display("[TB] FAIL b2b_accept: got %b, expected %b", {sram_ce_n, sram_oe_n, bus.sram_ready}, 3'b000); end
    c = 1;
    while (bus.sram_ack !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    bus.sram_req = 1'b0;
    checks++;
    if (c !== 2 + 2 * R || bus.sram_rdata !== 32'h1234BEEF)
      begin errors++; $display("[TB] FAIL b2b_second: got ack@%0d data %h, expected ack@%0d data %h", c, bus.sram_rdata, 2 + 2 * R, 32'h1234BEEF); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_req_drop();
    int n;
`ifdef SRAM_BURST_CANCEL_EN
    n = (20 - 1) / R + 1;
`else
    n = 128;
`endif
    run_txn(1'b0, 24'h003000, 32'h0, 8'd128, 20, 1'b0);
    checks++;
    if (beat_data.size() !== n || ack_cyc !== 2 + n * R)
      begin errors++; $display("[TB] FAIL req_drop: got %0d beats ack@%0d, expected %0d beats ack@%0d", beat_data.size(), ack_cyc, n, 2 + n * R); end
    checks++;
    if (beat_data.size() > 0 && beat_data[$] !== ref_rd(24'h003000 + 24'(beat_data.size() - 1)))
      begin errors++; $display("[TB] FAIL req_drop_data: got %h, expected %h", beat_data[$], ref_rd(24'h003000 + 24'(beat_data.size() - 1))); end
  endtask

  task automatic test_random();
    bit          we;
    logic [23:0] a;
    logic [31:0] wd;
    logic [7:0]  len;
    int          exp_ack;
    for (int t = 0; t < 16; t++) begin
      we  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? 24'hFFFFF0 + 24'($urandom_range(0, 15)) : 24'($urandom);
      wd  = $urandom;
      len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 16));
      run_txn(we, a, wd, len, 0, 1'b0);
      exp_ack = we ? 1 + 2 * W : (len == 0 ? 2 + 2 * R : 2 + int'(len) * R);
      checks++;
      if (timed_out || ack_cyc !== exp_ack || ack_cnt !== 1 || rdy_cyc !== exp_ack + 2)
        begin errors++; $display("[TB] FAIL rand%0d_timing: got ack@%0d x%0d ready@%0d, expected ack@%0d x1 ready@%0d", t, ack_cyc, ack_cnt, rdy_cyc, exp_ack, exp_ack + 2); end
      if (we) begin
        ref_mem[a] = wd[15:0];
        ref_mem[a + 24'd1] = wd[31:16];
        checks++;
        if ({sram_rd(a + 24'd1), sram_rd(a)} !== wd)
          begin errors++; $display("[TB] FAIL rand%0d_write: got %h, expected %h", t, {sram_rd(a + 24'd1), sram_rd(a)}, wd); end
      end else if (len == 0) begin
        checks++;
        if (rdata_at_ack !== {ref_rd(a + 24'd1), ref_rd(a)})
          begin errors++; $display("[TB] FAIL rand%0d_read: got %h, expected %h", t, rdata_at_ack, {ref_rd(a + 24'd1), ref_rd(a)}); end
      end else begin
        checks++;
        if (beat_data.size() !== int'(len))
          begin errors++; $display("[TB] FAIL rand%0d_beats: got %0d, expected %0d", t, beat_data.size(), len); end
        for (int k = 0; k < beat_data.size() && k < int'(len); k++) begin
          checks++;
          if (beat_data[k] !== ref_rd(a + 24'(k)))
            begin errors++; $display("[TB] FAIL rand%0d_beat%0d: got %h, expected %h", t, k, beat_data[k], ref_rd(a + 24'(k))); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_burst_128();
    test_burst_wrap();
    test_reset_abort();
    test_back_to_back();
    test_req_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
